stage_if_fetch: RTL

//  Instruction-fetch stage: owns the PC, issues requests to instruction memory, delivers
//  {pc, instruction, valid} to the IF/ID pipeline latch. Honours hazard-unit stall and

---
 rtl/cpu_fetch_pkg.sv | 15 +
 rtl/stage_if_fetch_next_pc.sv | 31 +++
 rtl/stage_if_fetch.sv | 119 +++++++++++
 3 files changed

// File: rtl/cpu_fetch_pkg.sv
// Shared fetch-stage types and constants.
// FSM encoding, NOP word and default PC parameters.
package cpu_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READY,
        ST_BUSY
    } fetch_state_t;

    localparam logic [31:0] INSTR_NOP    = 32'h0000_0000;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam int          DEF_PC_STEP  = 4;

endpackage

// File: rtl/stage_if_fetch_next_pc.sv
// Next-PC selection for the fetch stage.
// Macro IF_ALIGN_CHECK_EN keeps redirect targets unmasked.
module fetch_next_pc
    import cpu_fetch_pkg::*;
#(
    parameter int PC_STEP = DEF_PC_STEP
) (
    input  logic [31:0] pc,
    input  logic        branch_enable,
    input  logic [31:0] branch_target,
    input  logic        pending_valid,
    input  logic [31:0] pending_target,
    output logic [31:0] redirect_target,
    output logic [31:0] capture_pc
);

    // Live redirect beats a stored one, which beats sequential flow.
    always_comb begin
        redirect_target = branch_target;
`ifndef IF_ALIGN_CHECK_EN
        redirect_target[1:0] = 2'b00;
`endif
        if (branch_enable)
            capture_pc = redirect_target;
        else if (pending_valid)
            capture_pc = pending_target;
        else
            capture_pc = pc + 32'(PC_STEP);
    end

endmodule

// File: rtl/stage_if_fetch.sv
// Instruction-fetch stage with delay-slot redirect handling.
// Macro IF_ALIGN_CHECK_EN adds if_exception and misaligned-fetch trapping.
module stage_if_fetch
    import cpu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter int          PC_STEP  = DEF_PC_STEP
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_enable,
    input  logic [31:0] branch_target,
    output logic        imem_request,
    output logic [31:0] imem_address,
    input  logic        imem_ready,
    input  logic [31:0] imem_data,
    output logic [31:0] if_register_pc,
    output logic [31:0] if_instruction,
    output logic        if_valid
`ifdef IF_ALIGN_CHECK_EN
    ,
    output logic        if_exception
`endif
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic         pending_valid;
    logic [31:0]  pending_target;
    logic [31:0]  redirect_target;
    logic [31:0]  capture_pc;
    logic         consume;
    logic         space;
    logic         misaligned;
    logic         capture;
    logic         fault;

    fetch_next_pc #(
        .PC_STEP(PC_STEP)
    ) u_next_pc (
        .pc             (pc),
        .branch_enable  (branch_enable),
        .branch_target  (branch_target),
        .pending_valid  (pending_valid),
        .pending_target (pending_target),
        .redirect_target(redirect_target),
        .capture_pc     (capture_pc)
    );

    // Request only when the output register can take the word.
    always_comb begin
        consume = if_valid & ~stall;
        space   = ~if_valid | consume;
`ifdef IF_ALIGN_CHECK_EN
        misaligned = (pc[1:0] != 2'b00);
`else
        misaligned = 1'b0;
`endif
        imem_request = (state == ST_BUSY) ||
                       ((state == ST_READY) && space && !misaligned);
        imem_address = pc;
        capture      = imem_request & imem_ready;
        fault        = (state == ST_READY) && space && misaligned;
    end

    // FSM, PC, pending redirect and IF/ID output register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state          <= ST_IDLE;
            pc             <= RESET_PC;
            pending_valid  <= 1'b0;
            pending_target <= 32'h0;
            if_register_pc <= 32'h0;
            if_instruction <= 32'h0;
            if_valid       <= 1'b0;
`ifdef IF_ALIGN_CHECK_EN
            if_exception   <= 1'b0;
`endif
        end else begin
            unique case (state)
                ST_IDLE:  state <= ST_READY;
                ST_READY: if (imem_request && !imem_ready) state <= ST_BUSY;
                ST_BUSY:  if (imem_ready) state <= ST_READY;
                default:  state <= ST_IDLE;
            endcase

            if (capture) begin
                if_register_pc <= pc;
                if_instruction <= imem_data;
                if_valid       <= 1'b1;
                pc             <= capture_pc;
                pending_valid  <= 1'b0;
`ifdef IF_ALIGN_CHECK_EN
                if_exception   <= 1'b0;
`endif
            end else if (fault) begin
                if_register_pc <= pc;
                if_instruction <= INSTR_NOP;
                if_valid       <= 1'b1;
`ifdef IF_ALIGN_CHECK_EN
                if_exception   <= 1'b1;
`endif
                if (branch_enable) pc <= redirect_target;
            end else begin
                if (consume) if_valid <= 1'b0;
                if (branch_enable) begin
                    if (imem_request) begin
                        pending_valid  <= 1'b1;
                        pending_target <= redirect_target;
                    end else begin
                        pc <= redirect_target;
                    end
                end
            end
        end
    end

endmodule
